// File: rtl/turbo_stream_rx.sv
// Hard-decision checker for a turbo encoder serial stream: re-encodes xk with the RSC, checks zk and tail.
// dout one cycle after each accepted data triplet; in_valid gaps stall everything, no backpressure output.
module turbo_stream_rx (
  input  logic        clock,
  input  logic        reset,
  input  logic        sof,
  input  logic        blocksize,
  input  logic        in_valid,
  input  logic        xk_in,
  input  logic        zk_in,
  input  logic        zk_prime_in,
  output logic        dout,
  output logic        dout_valid,
  output logic        blk_done,
  output logic        parity_err,
  output logic        tail_err,
  output logic [12:0] err_count,
  output logic        abort,
  output logic        busy,
  output logic [2:0]  d_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    TAIL   = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam logic [12:0] K_SMALL = 13'd40;
  localparam logic [12:0] K_LARGE = 13'd6144;
  localparam logic [12:0] ERR_MAX = 13'h1fff;

  state_t      state;
  state_t      state_nxt;
  logic [12:0] data_cnt;
  logic [1:0]  tail_cnt;
  logic        bs_q;
  logic [2:0]  rsc;          // {s2, s1, s0}

  logic        start;
  logic        in_data;
  logic        in_tail;
  logic        tail_chk;
  logic        last_data;
  logic        last_tail;
  logic [12:0] k_last;
  logic [2:0]  rsc_base;
  logic [2:0]  rsc_nxt;
  logic        x_eff;
  logic        fb;
  logic        z_exp;
  logic        mismatch;
  logic        tail_bad;
  logic        unused_zk_prime;

  // Encoder-2 parity is not checked by this block.
  assign unused_zk_prime = zk_prime_in;

  assign start     = sof & in_valid;
  assign in_data   = start | (in_valid & (state == DATA));
  assign in_tail   = ~start & in_valid & (state == TAIL);
  assign tail_chk  = in_tail & (tail_cnt != 2'd3);
  assign last_tail = in_tail & (tail_cnt == 2'd3);
  assign k_last    = (bs_q ? K_LARGE : K_SMALL) - 13'd1;
  assign last_data = ~start & in_valid & (state == DATA) & (data_cnt == k_last);

  // A new block starts from the all-zero trellis state on the sof triplet itself.
  assign rsc_base = start ? 3'b000 : rsc;
  assign x_eff    = in_tail ? (rsc_base[1] ^ rsc_base[2]) : xk_in;
  assign fb       = x_eff ^ rsc_base[1] ^ rsc_base[2];
  assign z_exp    = fb ^ rsc_base[0] ^ rsc_base[2];
  assign rsc_nxt  = {rsc_base[1], rsc_base[0], fb};

  assign mismatch = (in_data | tail_chk) & (zk_in != z_exp);
  assign tail_bad = tail_chk & ((xk_in != x_eff) |
                                ((tail_cnt == 2'd2) & (rsc_nxt != 3'b000)));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DATA;
      DATA:    if (last_data) state_nxt = TAIL;
      TAIL: begin
        if (start)          state_nxt = DATA;
        else if (last_tail) state_nxt = REPORT;
      end
      REPORT:  state_nxt = start ? DATA : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_cnt   <= 13'd0;
      tail_cnt   <= 2'd0;
      bs_q       <= 1'b0;
      rsc        <= 3'b000;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      abort      <= 1'b0;
      parity_err <= 1'b0;
      tail_err   <= 1'b0;
      err_count  <= 13'd0;
    end else begin
      state      <= state_nxt;
      dout_valid <= in_data;
      dout       <= in_data & xk_in;
      abort      <= start & ((state == DATA) | (state == TAIL));

      if (start) bs_q <= blocksize;

      if (start)        data_cnt <= 13'd1;
      else if (in_data) data_cnt <= data_cnt + 13'd1;

      if (start)        tail_cnt <= 2'd0;
      else if (in_tail) tail_cnt <= tail_cnt + 2'd1;

      // The fourth tail triplet belongs to encoder 2 and leaves the trellis alone.
      if (in_data | tail_chk) rsc <= rsc_nxt;

      if (start) begin
        parity_err <= mismatch;
        tail_err   <= 1'b0;
        err_count  <= {12'd0, mismatch};
      end else begin
        if (mismatch) parity_err <= 1'b1;
        if (tail_bad) tail_err   <= 1'b1;
        if (mismatch && (err_count != ERR_MAX)) err_count <= err_count + 13'd1;
      end
    end
  end

  assign blk_done = (state == REPORT);
  assign busy     = (state != IDLE);
  assign d_state  = {1'b0, state};

endmodule

// File: tb/tb_turbo_stream_rx.sv
// Randomized bench for turbo_stream_rx against a recurrence-form RSC reference model.
module tb_turbo_stream_rx;

  logic        clock = 1'b0;
  logic        reset;
  logic        sof;
  logic        blocksize;
  logic        in_valid;
  logic        xk_in;
  logic        zk_in;
  logic        zk_prime_in;
  logic        dout;
  logic        dout_valid;
  logic        blk_done;
  logic        parity_err;
  logic        tail_err;
  logic [12:0] err_count;
  logic        abort;
  logic        busy;
  logic [2:0]  d_state;

  int total = 0;
  int bad   = 0;
  int pcyc  = 0;
  int n_abort = 0;

  bit got_q[$];
  int dv_cyc_q[$];
  int done_q[$];
  int pe_q[$];
  int te_q[$];
  int ec_q[$];
  bit exp_q[$];

  bit xs[6148];
  bit zs[6148];
  bit av[6148];
  int flip_q[$];
  int first_drive;
  int last_drive;

  turbo_stream_rx dut (
    .clock(clock), .reset(reset), .sof(sof), .blocksize(blocksize),
    .in_valid(in_valid), .xk_in(xk_in), .zk_in(zk_in), .zk_prime_in(zk_prime_in),
    .dout(dout), .dout_valid(dout_valid), .blk_done(blk_done),
    .parity_err(parity_err), .tail_err(tail_err), .err_count(err_count),
    .abort(abort), .busy(busy), .d_state(d_state)
  );

  always #5 clock = ~clock;

  always @(posedge clock) pcyc <= pcyc + 1;

  always @(negedge clock) begin
    if (dout_valid) begin
      got_q.push_back(dout);
      dv_cyc_q.push_back(pcyc);
    end
    if (blk_done) begin
      done_q.push_back(pcyc);
      pe_q.push_back(int'(parity_err));
      te_q.push_back(int'(tail_err));
      ec_q.push_back(int'(err_count));
    end
    if (abort) n_abort <= n_abort + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Feedback value a[n]; the encoder starts from an all-zero history.
  function automatic bit a_at(input int i);
    return (i < 0) ? 1'b0 : av[i];
  endfunction

  // a[n] = x[n]^a[n-2]^a[n-3], z[n] = a[n]^a[n-1]^a[n-3]; tail forces a[n]=0.
  task automatic build(input int k, input int dmode, input int tflip, output int nerr);
    bit f;
    for (int i = 0; i < k + 4; i++) begin
      if (i < k) begin
        xs[i] = (dmode == 2) ? 1'($urandom) : ((dmode == 1) && (i == 0));
        f = xs[i] ^ a_at(i - 2) ^ a_at(i - 3);
      end else if (i < k + 3) begin
        xs[i] = a_at(i - 2) ^ a_at(i - 3);
        f = 1'b0;
      end else begin
        xs[i] = 1'($urandom);
        f = 1'b0;
      end
      av[i] = f;
      zs[i] = (i < k + 3) ? (f ^ a_at(i - 1) ^ a_at(i - 3)) : 1'($urandom);
    end
    if (tflip >= 0) xs[k + tflip] = ~xs[k + tflip];
    nerr = flip_q.size();
    foreach (flip_q[j]) zs[flip_q[j]] = ~zs[flip_q[j]];
  endtask

  task automatic rand_flips(input int k, input int n);
    int p;
    bit dup;
    flip_q.delete();
    while (flip_q.size() < n) begin
      p = int'($urandom_range(k + 2, 0));
      dup = 1'b0;
      foreach (flip_q[j]) if (flip_q[j] == p) dup = 1'b1;
      if (!dup) flip_q.push_back(p);
    end
  endtask

  task automatic send_trip(input bit s, input bit bs, input bit x, input bit z);
    @(negedge clock);
    sof         = s;
    in_valid    = 1'b1;
    blocksize   = s ? bs : 1'($urandom);
    xk_in       = x;
    zk_in       = z;
    zk_prime_in = 1'($urandom);
    last_drive  = pcyc;
  endtask

  // Idle cycles carry random sof/data that must be ignored without in_valid.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid    = 1'b0;
      sof         = 1'($urandom);
      blocksize   = 1'($urandom);
      xk_in       = 1'($urandom);
      zk_in       = 1'($urandom);
      zk_prime_in = 1'($urandom);
    end
  endtask

  task automatic send_blk(input int k, input bit bs, input int n_send,
                          input int gap_every, input int gap_len, input bit rgaps);
    for (int i = 0; i < n_send; i++) begin
      if (gap_every > 0 && i > 0 && (i % gap_every) == 0) idle(gap_len);
      else if (rgaps && $urandom_range(7, 0) == 0) idle(int'($urandom_range(3, 1)));
      send_trip(i == 0, bs, xs[i], zs[i]);
      if (i == 0) first_drive = last_drive;
      if (i < k) exp_q.push_back(xs[i]);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_q.size() < target && n < 20) begin
      sync();
      n++;
    end
  endtask

  task automatic check_stream(input string nm, input int g0, input int e0);
    int nbad;
    int n;
    nbad = 0;
    n = got_q.size() - g0;
    if (exp_q.size() - e0 < n) n = exp_q.size() - e0;
    for (int i = 0; i < n; i++) if (got_q[g0 + i] != exp_q[e0 + i]) nbad++;
    chk({nm, "_dv_count"}, got_q.size() - g0, exp_q.size() - e0);
    chk({nm, "_dout_bits"}, nbad, 0);
  endtask

  task automatic outputs_zero(input string nm);
    chk({nm, "_dout"}, int'(dout), 0);
    chk({nm, "_dout_valid"}, int'(dout_valid), 0);
    chk({nm, "_blk_done"}, int'(blk_done), 0);
    chk({nm, "_parity_err"}, int'(parity_err), 0);
    chk({nm, "_tail_err"}, int'(tail_err), 0);
    chk({nm, "_err_count"}, int'(err_count), 0);
    chk({nm, "_abort"}, int'(abort), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_d_state"}, int'(d_state), 0);
  endtask

  task automatic do_block(input string nm, input int k, input bit bs, input int dmode,
                          input int tflip, input int gap_every, input int gap_len, input bit rgaps);
    int g0, e0, d0, a0, nerr;
    sync();
    g0 = got_q.size(); e0 = exp_q.size(); d0 = done_q.size(); a0 = n_abort;
    build(k, dmode, tflip, nerr);
    send_blk(k, bs, k + 4, gap_every, gap_len, rgaps);
    idle(1);
    wait_done(d0 + 1);
    chk({nm, "_done_count"}, done_q.size() - d0, 1);
    if (done_q.size() > d0) begin
      chk({nm, "_done_cycle"}, done_q[d0], last_drive + 1);
      chk({nm, "_parity_err"}, pe_q[d0], int'(nerr != 0));
      chk({nm, "_tail_err"}, te_q[d0], int'(tflip >= 0));
      chk({nm, "_err_count"}, ec_q[d0], nerr);
    end
    if (dv_cyc_q.size() > g0) chk({nm, "_dv_latency"}, dv_cyc_q[g0], first_drive + 1);
    check_stream(nm, g0, e0);
    chk({nm, "_abort"}, n_abort - a0, 0);
    idle(3);
    sync();
    chk({nm, "_busy_after"}, int'(busy), 0);
    chk({nm, "_state_after"}, int'(d_state), 0);
    chk({nm, "_err_hold"}, int'(err_count), nerr);
    chk({nm, "_done_once"}, done_q.size() - d0, 1);
  endtask

  initial begin
    int g0, e0, d0, a0, nerr, last_a;

    // Reset dominates even with a live sof triplet on the inputs.
    reset = 1'b1; sof = 1'b1; in_valid = 1'b1; blocksize = 1'b0;
    xk_in = 1'b1; zk_in = 1'b1; zk_prime_in = 1'b1;
    repeat (3) sync();
    outputs_zero("reset");
    @(negedge clock);
    reset = 1'b0; sof = 1'b0; in_valid = 1'b0;

    // in_valid without sof in IDLE produces nothing.
    g0 = got_q.size();
    repeat (5) send_trip(1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);
    sync();
    chk("idle_no_dv", got_q.size() - g0, 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_no_done", done_q.size(), 0);

    flip_q.delete();
    do_block("zeros", 40, 1'b0, 0, -1, 0, 0, 1'b0);
    do_block("onehot", 40, 1'b0, 1, -1, 0, 0, 1'b0);
    flip_q.delete(); flip_q.push_back(5); flip_q.push_back(17);
    do_block("onehot_flip", 40, 1'b0, 1, -1, 0, 0, 1'b0);
    flip_q.delete();
    do_block("tail_x1", 40, 1'b0, 2, 1, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rand_flips(40, int'($urandom_range(4, 0)));
      do_block($sformatf("rand%0d", r), 40, 1'b0, 2, int'($urandom_range(3, 0)) - 1, 0, 0, 1'b1);
    end

    flip_q.delete();
    do_block("k6144", 6144, 1'b1, 2, -1, 100, 3, 1'b0);

    // sof accepted in REPORT: first block still reports, second starts clean.
    sync();
    g0 = got_q.size(); e0 = exp_q.size(); d0 = done_q.size(); a0 = n_abort;
    rand_flips(40, 2);
    build(40, 2, -1, nerr);
    send_blk(40, 1'b0, 44, 0, 0, 1'b0);
    last_a = last_drive;
    flip_q.delete();
    build(40, 2, -1, nerr);
    send_blk(40, 1'b0, 44, 0, 0, 1'b0);
    idle(1);
    wait_done(d0 + 2);
    chk("b2b_done_count", done_q.size() - d0, 2);
    if (done_q.size() >= d0 + 2) begin
      chk("b2b_done_cycle_a", done_q[d0], last_a + 1);
      chk("b2b_done_cycle_b", done_q[d0 + 1], last_drive + 1);
      chk("b2b_err_count_a", ec_q[d0], 2);
      chk("b2b_parity_err_a", pe_q[d0], 1);
      chk("b2b_err_count_b", ec_q[d0 + 1], 0);
      chk("b2b_parity_err_b", pe_q[d0 + 1], 0);
    end
    check_stream("b2b", g0, e0);
    chk("b2b_abort", n_abort - a0, 0);

    // sof at data bit 20, then reset at data bit 10 of the new block.
    idle(2);
    sync();
    g0 = got_q.size(); e0 = exp_q.size(); d0 = done_q.size(); a0 = n_abort;
    build(40, 2, -1, nerr);
    send_blk(40, 1'b0, 20, 0, 0, 1'b0);
    build(40, 2, -1, nerr);
    send_blk(40, 1'b0, 10, 0, 0, 1'b0);
    idle(1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    sync();
    chk("abort_pulses", n_abort - a0, 1);
    chk("abort_no_done", done_q.size() - d0, 0);
    check_stream("abort", g0, e0);
    outputs_zero("midrst");
    sync();
    @(negedge clock);
    reset = 1'b0;
    g0 = got_q.size();
    repeat (3) send_trip(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    sync();
    chk("postrst_no_dv", got_q.size() - g0, 0);
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_no_done", done_q.size() - d0, 0);
    chk("postrst_abort", n_abort - a0, 1);

    rand_flips(40, 1);
    do_block("postrst_blk", 40, 1'b0, 2, -1, 0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/turbo_stream_rx.md
TURBO_STREAM_RX -- requirements
Module: turbo_stream_rx

Receive end of the turbo encoder serial output (xk, zk, zk'). Recovers systematic bits, re-encodes them with the constituent RSC, and checks parity and trellis termination. This is a hard-decision, noiseless-link checker, not an iterative decoder.

Interface
REQ-001 SHALL provide: clock  input  1  system clock, rising edge.
REQ-002 SHALL provide: reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL provide: sof  input  1  start of block; qualified by in_valid, marks the first data triplet.
REQ-004 SHALL provide: blocksize  input  1  sampled with sof; 0 = K of 40, 1 = K of 6144.
REQ-005 SHALL provide: in_valid  input  1  xk_in/zk_in/zk_prime_in carry a triplet this cycle.
REQ-006 SHALL provide: xk_in, zk_in, zk_prime_in  input  1 each  systematic, parity-1 and parity-2 bits.
REQ-007 SHALL provide: dout  output  1  recovered systematic bit.
REQ-008 SHALL provide: dout_valid  output  1  dout valid.
REQ-009 SHALL provide: blk_done  output  1  one-cycle pulse when the block result is final.
REQ-010 SHALL provide: parity_err, tail_err  output  1 each  sticky per block, valid with blk_done.
REQ-011 SHALL provide: err_count  output  13  parity mismatches in the current block.
REQ-012 SHALL provide: abort  output  1  one-cycle pulse when a block is abandoned.
REQ-013 SHALL provide: busy  output  1  state not IDLE.
REQ-014 SHALL provide: d_state  output  3  current FSM state, for debug.

Function
REQ-015 SHALL run FSM states IDLE=0, DATA=1, TAIL=2, REPORT=3, with d_state equal to the encoding.
REQ-016 SHALL latch blocksize on sof&in_valid and hold it for the whole block.
REQ-017 SHALL, on sof&in_valid in IDLE: go to DATA, treat that triplet as data bit 0, and clear the RSC state, err_count and both error flags.
REQ-018 SHALL advance the data counter, tail counter and RSC only on cycles where in_valid=1; in_valid gaps of any length SHALL stall without error.
REQ-019 SHALL implement the RSC with state s0,s1,s2 (D, D^2, D^3):
  - a = x ^ s1 ^ s2
  - zexp = a ^ s0 ^ s2
  - next state (s0,s1,s2) <= (a, s0, s1)
REQ-020 SHALL, in DATA, drive x = xk_in into the RSC and register dout = xk_in with dout_valid=1 exactly one cycle after each accepted triplet.
REQ-021 SHALL, in DATA, flag a mismatch whenever zk_in != zexp.
REQ-022 SHALL go from DATA to TAIL after the K-th accepted data triplet; dout_valid SHALL assert exactly K times per block.
REQ-023 SHALL, for tail triplets 0..2: run the RSC in termination mode (x = s1^s2, so a=0), set tail_err if xk_in != s1^s2, and flag a mismatch if zk_in != zexp.
REQ-024 SHALL accept tail triplet 3, which carries the encoder-2 remainder, and discard it; zk_prime_in SHALL be ignored in all states.
REQ-025 SHALL set tail_err if the RSC state is not 000 after tail triplet 2.
REQ-026 SHALL, for each mismatch: set parity_err and increment err_count, saturating at 8191.
REQ-027 SHALL go from TAIL to REPORT after the 4th tail triplet, pulse blk_done for 1 cycle in REPORT, then return to IDLE.
REQ-028 SHALL keep err_count and both error flags held until the next sof.
REQ-029 SHALL, on sof&in_valid in DATA or TAIL: pulse abort, raise no blk_done, and restart as in REQ-017 in the same cycle.
REQ-030 SHALL, on sof&in_valid in REPORT: pulse blk_done, then enter DATA directly, with that triplet as data bit 0.
REQ-031 SHALL ignore in_valid without sof in IDLE, producing no output.

Reset
REQ-032 SHALL, while reset=1: force state IDLE, RSC 000, counters 0, and all outputs 0, including err_count=0 and d_state=0.
REQ-033 SHALL, on reset assertion mid-block: discard the block with no blk_done and no abort pulse, and restart only on the next sof.

Verification
REQ-034 SHALL pass: K=40, all xk=0 and zk=0, 4 all-zero tail triplets -> 40 dout=0, blk_done at 45 accepted-cycle offset +1, parity_err=0, tail_err=0, err_count=0.
REQ-035 SHALL pass: K=40, xk bit0=1 and the rest 0, zk from the golden RSC (first four 1,1,1,1) plus the correct tail -> parity_err=0, tail_err=0, dout bit0=1.
REQ-036 SHALL pass: the REQ-035 stream with zk bits 5 and 17 inverted -> parity_err=1, err_count=2, tail_err=0.
REQ-037 SHALL pass: K=6144 random data, correct encoding, with in_valid deasserted for 3 cycles every 100 triplets -> exactly 6144 dout_valid, zero errors.
REQ-038 SHALL pass: K=40 with tail triplet 1 xk inverted -> tail_err=1, blk_done asserted.
REQ-039 SHALL pass: sof at data bit 20, then reset asserted at data bit 10 of the following block -> abort pulse at the first event, all outputs 0 after reset, no blk_done.
